// File: rtl/fifo8_ctrl_pkg.sv
// Shared sizes and the per-cycle operation type for the fifo8_ctrl RAM-fronting FIFO.
package fifo8_ctrl_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int DEPTH   = 8;
  localparam int COUNT_W = 4;

  // The single RAM port does at most one of these per cycle.
  typedef enum logic [1:0] {
    OP_IDLE   = 2'd0,
    OP_BYPASS = 2'd1,
    OP_WRITE  = 2'd2,
    OP_REFILL = 2'd3
  } op_e;

endpackage

// File: rtl/fifo8_ctrl_ptr_ctr3.sv
// 3-bit wrapping pointer with enable; wraps 7->0 naturally.
module ptr_ctr3
  import fifo8_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_ptr
);

  logic [ADDR_W-1:0] r_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_ptr <= '0;
    else if (i_en) r_ptr <= r_ptr + ADDR_W'(1);
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo8_ctrl.sv
// Valid/ready FIFO controller in front of an external 8x16 RAM; head word lives in a local
// register, giving 9 words of capacity.
module fifo8_ctrl
  import fifo8_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] count,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_in,
  output logic               ram_write,
  input  logic [DATA_W-1:0]  ram_out
);

  logic [DATA_W-1:0]  r_head_q;
  logic               r_head_v;
  logic [COUNT_W-1:0] r_ram_count;

  logic [ADDR_W-1:0]  w_wr_ptr;
  logic [ADDR_W-1:0]  w_rd_ptr;
  logic               w_pop;
  logic               w_head_free;
  logic               w_ram_empty;
  logic               w_ram_full;
  logic               w_refill;
  logic               w_in_ready;
  logic               w_push;
  op_e                w_op;

  assign w_pop       = r_head_v & out_ready;
  assign w_head_free = !r_head_v | w_pop;
  assign w_ram_empty = (r_ram_count == '0);
  assign w_ram_full  = (r_ram_count == COUNT_W'(DEPTH));
  assign w_refill    = !w_ram_empty & w_head_free;
  // Refill owns the RAM port, so accepting is blocked that cycle; rst_n gates it during reset.
  assign w_in_ready  = rst_n & !w_ram_full & !w_refill;
  assign w_push      = in_valid & w_in_ready;

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    w_op = OP_IDLE;
    if (w_refill)                          w_op = OP_REFILL;
    else if (w_push && w_ram_empty && w_head_free) w_op = OP_BYPASS;
    else if (w_push)                       w_op = OP_WRITE;
  end

  ptr_ctr3 u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_op == OP_WRITE),
    .o_ptr (w_wr_ptr)
  );

  ptr_ctr3 u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_op == OP_REFILL),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_q    <= '0;
      r_head_v    <= 1'b0;
      r_ram_count <= '0;
    end else begin
      unique case (w_op)
        OP_REFILL: begin
          r_head_q    <= ram_out;
          r_head_v    <= 1'b1;
          r_ram_count <= r_ram_count - COUNT_W'(1);
        end
        OP_BYPASS: begin
          r_head_q <= in_data;
          r_head_v <= 1'b1;
        end
        OP_WRITE: r_ram_count <= r_ram_count + COUNT_W'(1);
        default:  if (w_pop) r_head_v <= 1'b0;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_head_q;
  assign out_valid = r_head_v;
  assign count     = r_ram_count + COUNT_W'(r_head_v);
  assign ram_write = (w_op == OP_WRITE);
  assign ram_addr  = ram_write ? w_wr_ptr : w_rd_ptr;
  assign ram_in    = in_data;

endmodule

// File: doc/fifo8_ctrl.md
Name: fifo8_ctrl

Overview:
- Valid/ready FIFO controller that fronts the team's 8x16 RAM (3-bit addr, write-enable, combinational read, write on clk rising edge).
- Generates the RAM's addr/in/write, consumes its read data, and holds the FIFO head in a local register.
- Capacity is 9 words: 8 in RAM plus 1 in the head register.
- Sits between a word producer (e.g. a serial/IO receiver) and the CPU-side consumer.

Parameters:
- DATA_W, 16, word width (fixed to the RAM width).
- ADDR_W, 3, RAM address width (fixed; DEPTH = 8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  16  producer word.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  controller accepts; push = in_valid & in_ready.
- out_data  out  16  head word (registered).
- out_valid  out  1  head register holds a word.
- out_ready  in  1  consumer takes; pop = out_valid & out_ready.
- count  out  4  words held, 0..9 (ram_count + out_valid).
- ram_addr  out  3  to RAM addr.
- ram_in  out  16  to RAM in (= in_data).
- ram_write  out  1  to RAM write.
- ram_out  in  16  from RAM out (combinational read of ram_addr).

Behaviour:
- State: wr_ptr[2:0], rd_ptr[2:0], ram_count[3:0] (0..8), head_q[15:0], head_v.
- Reset (rst_n low, async): all state 0. out_valid=0, out_data=0, count=0.
- During reset, in_ready and ram_write are forced 0 combinationally.
- refill = (ram_count != 0) & (!head_v | pop).
- in_ready = (ram_count != 8) & !refill. It is combinational on out_ready (documented path).
- bypass = push & (ram_count == 0) & (!head_v | pop).
  - Next edge: head_q <= in_data, head_v <= 1.
  - No RAM write; pointers unchanged.
- RAM write = push & !bypass.
  - ram_write=1, ram_addr=wr_ptr.
  - Next edge: wr_ptr += 1 (mod 8, natural wrap 7->0), ram_count += 1.
- Refill (refill=1; push is impossible that cycle because in_ready=0):
  - ram_addr = rd_ptr, ram_write = 0.
  - Next edge: head_q <= ram_out, head_v <= 1, rd_ptr += 1 (wrap 7->0), ram_count -= 1.
- Pop with no refill and no bypass: head_v <= 0 next edge. head_q retains its value; out_data is don't-care-stable.
- ram_addr defaults to rd_ptr when idle. ram_write is never 1 except on a RAM write.
- Port arbitration: the single RAM port is never read for refill and written in the same cycle. Refill has priority so the head never starves while RAM holds data.
- Latency:
  - Empty FIFO: push at cycle N gives out_valid=1 at N+1 (bypass).
  - Word stored in RAM: reaches the head 1 cycle after the head frees.
- Full (count=9: ram_count=8, head_v=1):
  - With out_ready=0: in_ready=0.
  - With out_ready=1: refill is asserted, so in_ready is still 0. The slot opens the following cycle.
- Empty (count=0): out_valid=0; pop impossible.
- Ordering is strict FIFO across bypass/RAM paths. Bypass happens only when RAM is empty, so order is preserved.
- Reset mid-operation: contents are discarded, pointers return to 0. RAM contents are not cleared but become unreachable.
- Invariants (assert in bench):
  - ram_count == (wr_ptr - rd_ptr) mod 8, except when ram_count is 8 with pointers equal.
  - ram_count > 0 implies head_v, at every edge.

Decomposition:
- Shared package: DATA_W=16, ADDR_W=3, DEPTH=8, COUNT_W=4.
- One natural sub-module: ptr_ctr3 (3-bit wrapping incrementer with enable, async active-low reset), used for wr_ptr and rd_ptr.
- The RAM is instantiated by the parent, not inside this block.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, ram_write=0, out_valid=0, count=0. Release -> in_ready=1.
- Bypass: empty, push 0x1234 at cycle N -> cycle N+1 out_valid=1, out_data=0x1234, count=1, ram_write never pulsed.
- Fill: out_ready=0, push 0x0001..0x0009 -> count=9, in_ready=0 after the 9th. ram_write pulsed 8 times at addrs 0..7. A 10th offer is not accepted.
- Drain and refill: from full, out_ready=1 continuously -> out_data 0x0001..0x0009 in order. in_ready=0 in each refill cycle. count reaches 0 and out_valid drops.
- Wrap: 20 words through with random in_valid/out_ready -> output order exact. wr_ptr/rd_ptr wrap 7->0 at least twice. Invariants hold every cycle.
- Mid-op reset: 5 words queued, pulse rst_n low between edges -> outputs 0 immediately (async). After release, push 0xBEEF -> out_data=0xBEEF next cycle, count=1.
